// File: rtl/cocc_encoder.sv
// COCC instruction encoder: turns symbolic instructions into 1- or 2-byte COCC code written
// sequentially into program memory. Optional running XOR checksum under COCC_ENC_CHECKSUM_EN.
module cocc_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_a,
  input  logic [2:0]        in_b,
  input  logic [7:0]        in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              full,
  output logic              error,
  output logic [ADDR_W:0]   count
`ifdef COCC_ENC_CHECKSUM_EN
  ,
  output logic [7:0]        csum
`endif
);

  localparam logic [ADDR_W:0] CntFull = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntLast = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {StIdle, StEmit0, StEmit1} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     count_q;
  logic [7:0]          byte0_q;
  logic [7:0]          imm_q;
  logic                two_q;
  logic                error_q;
  logic                illegal;
  logic                two_byte;
  logic                accept;
`ifdef COCC_ENC_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  function automatic logic [7:0] encode(input logic [3:0] op, input logic [2:0] a,
                                        input logic [2:0] b);
    logic [7:0] enc;
    enc = 8'h00;
    case (op)
      4'd0:    enc = 8'h00;
      4'd1:    enc = 8'h01;
      4'd2:    enc = 8'h02;
      4'd3:    enc = 8'h03;
      4'd4:    enc = {2'b00, 3'b001, b};
      4'd5:    enc = {2'b00, 3'b010, b};
      4'd6:    enc = {2'b00, 3'b011, b};
      4'd7:    enc = {2'b00, 3'b100, b};
      4'd8:    enc = {2'b00, 3'b101, b};
      4'd9:    enc = {2'b00, 3'b110, b};
      4'd10:   enc = {2'b00, 3'b111, b};
      4'd11:   enc = {2'b10, 3'b000, b};
      4'd12:   enc = {2'b01, a, b};
      default: enc = 8'h00;
    endcase
    return enc;
  endfunction

  assign illegal  = (in_op > 4'd12);
  assign two_byte = (in_op == 4'd6) || (in_op == 4'd11);
  assign full     = (count_q == CntFull);
  assign in_ready = (state_q == StIdle) && !full;
  assign accept   = in_valid && in_ready;
  assign count    = count_q;
  assign error    = error_q;
`ifdef COCC_ENC_CHECKSUM_EN
  assign csum     = csum_q;
`endif

  // Writes are gated combinationally so a clear or reset cycle never reaches memory.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    if (!rst && !clear) begin
      case (state_q)
        StEmit0: begin
          mem_we    = 1'b1;
          mem_addr  = ptr_q;
          mem_wdata = byte0_q;
        end
        StEmit1: begin
          mem_we    = 1'b1;
          mem_addr  = ptr_q;
          mem_wdata = imm_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      count_q <= '0;
      byte0_q <= 8'h00;
      imm_q   <= 8'h00;
      two_q   <= 1'b0;
      error_q <= 1'b0;
`ifdef COCC_ENC_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      error_q <= 1'b0;
      if (clear) begin
        state_q <= StIdle;
        ptr_q   <= '0;
        count_q <= '0;
`ifdef COCC_ENC_CHECKSUM_EN
        csum_q  <= 8'h00;
`endif
      end else begin
        case (state_q)
          StIdle: begin
            if (accept) begin
              // A two-byte op needing the last free byte plus one more is rejected outright.
              if (illegal || (two_byte && (count_q == CntLast))) begin
                error_q <= 1'b1;
              end else begin
                byte0_q <= encode(in_op, in_a, in_b);
                imm_q   <= in_imm;
                two_q   <= two_byte;
                state_q <= StEmit0;
              end
            end
          end
          StEmit0: begin
            ptr_q   <= ptr_q + 1'b1;
            count_q <= count_q + 1'b1;
`ifdef COCC_ENC_CHECKSUM_EN
            csum_q  <= csum_q ^ byte0_q;
`endif
            state_q <= two_q ? StEmit1 : StIdle;
          end
          StEmit1: begin
            ptr_q   <= ptr_q + 1'b1;
            count_q <= count_q + 1'b1;
`ifdef COCC_ENC_CHECKSUM_EN
            csum_q  <= csum_q ^ imm_q;
`endif
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cocc_encoder.sv
// Scoreboard bench for cocc_encoder: driver predicts memory writes and error pulses per
// accepted instruction; a negedge monitor compares every cycle against those predictions.
module tb_cocc_encoder;

  localparam int unsigned AW    = 3;
  localparam int          Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = 4'd0;
  logic [2:0]    in_a = 3'd0;
  logic [2:0]    in_b = 3'd0;
  logic [7:0]    in_imm = 8'd0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          full;
  logic          error;
  logic [AW:0]   count;
`ifdef COCC_ENC_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  always #5 clk = ~clk;

  cocc_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_imm    (in_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .full      (full),
    .error     (error),
`ifdef COCC_ENC_CHECKSUM_EN
    .csum      (csum),
`endif
    .count     (count)
  );

  typedef struct {
    int         due;
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t  wq[$];
  int   eq[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   chk = 1'b0;
  int   drv_cnt = 0;
  int   mon_cnt = 0;
  logic [7:0] mon_csum = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference encoding from the opcode table, computed arithmetically.
  function automatic logic [7:0] ref_byte0(input int op, input int a, input int b);
    int v;
    if (op < 4)       v = op;
    else if (op <= 10) v = ((op - 3) << 3) | b;
    else if (op == 11) v = 8'h80 | b;
    else               v = 8'h40 | (a << 3) | b;
    return 8'(v);
  endfunction

  // Monitor: one cycle of expectations per negedge.
  always @(negedge clk) begin
    bit  sched;
    bit  exp_we;
    bit  exp_err;
    int  exp_addr;
    int  exp_data;
    wr_t w;
    if (chk) begin
      while (wq.size() > 0 && wq[0].due < cyc) begin
        w = wq.pop_front();
        check("stale_write", w.due, cyc);
      end
      sched    = (wq.size() > 0) && (wq[0].due == cyc);
      exp_we   = sched && !rst && !clear;
      exp_addr = 0;
      exp_data = 0;
      w.data   = 8'h00;
      if (sched) begin
        w = wq.pop_front();
        if (exp_we) begin
          exp_addr = w.addr;
          exp_data = int'(w.data);
        end
      end
      check("mem_we", int'(mem_we), int'(exp_we));
      check("mem_addr", int'(mem_addr), exp_addr);
      check("mem_wdata", int'(mem_wdata), exp_data);
      exp_err = (eq.size() > 0) && (eq[0] == cyc);
      if (exp_err) void'(eq.pop_front());
      check("error", int'(error), int'(exp_err));
      check("count", int'(count), mon_cnt);
      check("full", int'(full), int'(mon_cnt == Depth));
      check("in_ready", int'(in_ready), int'(!sched && mon_cnt != Depth));
`ifdef COCC_ENC_CHECKSUM_EN
      check("csum", int'(csum), int'(mon_csum));
`endif
      if (exp_we) begin
        mon_cnt++;
        mon_csum ^= w.data;
      end
      if (rst || clear) begin
        mon_cnt  = 0;
        mon_csum = 8'h00;
        wq.delete();
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send(input int op, input int a, input int b, input int imm, input bit clr0);
    int         tries;
    int         k;
    bit         two;
    logic [7:0] b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_op    = 4'(op);
    in_a     = 3'(a);
    in_b     = 3'(b);
    in_imm   = 8'(imm);
    tries    = 0;
    while (!in_ready && tries < 20) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL handshake: in_ready got 0 expected 1 within 20 cycles (cycle %0d)", cyc);
      in_valid = 1'b0;
      return;
    end
    k   = cyc + 1;
    two = (op == 6) || (op == 11);
    if (op > 12 || (two && drv_cnt == Depth - 1)) begin
      eq.push_back(k);
    end else begin
      b0 = ref_byte0(op, a, b);
      wq.push_back('{due: k, addr: drv_cnt % Depth, data: b0});
      drv_cnt++;
      if (two) begin
        wq.push_back('{due: k + 1, addr: drv_cnt % Depth, data: 8'(imm)});
        drv_cnt++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (clr0) begin
      clear   = 1'b1;
      drv_cnt = 0;
      @(posedge clk); #1;
      clear = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear   = 1'b1;
    drv_cnt = 0;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    rst     = 1'b1;
    drv_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int r;
    int op;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk = 1'b1;

    // Directed: encodings, sequential addressing, illegal op, last-byte rejection, full.
    send(12, 3, 5, 0, 0);
    send(6, 5, 2, 8'hA5, 0);
    send(5, 6, 4, 0, 0);
    send(11, 0, 1, 8'h40, 0);
    send(14, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(6, 0, 1, 8'h33, 0);
    send(2, 0, 0, 0, 0);
    idle(3);
    do_clear();
    // Clear and reset landing on the immediate byte of an LDI.
    send(6, 0, 3, 8'h77, 0);
    do_clear();
    send(0, 0, 0, 0, 0);
    send(6, 0, 4, 8'h5A, 0);
    do_rst();
    send(1, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (drv_cnt == Depth) begin
        idle(int'($urandom_range(0, 2)));
        if (r < 50) do_clear();
        else        do_rst();
      end else if (r < 4) begin
        do_clear();
      end else if (r < 6) begin
        do_rst();
      end else if (r < 10) begin
        send(int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 1'b1);
      end else if (r < 14) begin
        send((r < 12) ? 6 : 11, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)), 1'b0);
        do_clear();
      end else begin
        op = (r < 20) ? int'($urandom_range(13, 15)) : int'($urandom_range(0, 12));
        send(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)), 1'b0);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end

    idle(4);
    check("write_queue_drained", wq.size(), 0);
    check("error_queue_drained", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cocc_encoder.md
Name: cocc_encoder

Overview:
- Reverse path of the COCC instruction decoder.
- Accepts symbolic instructions (opcode enum plus operands/immediate) over a valid/ready handshake.
- Encodes each instruction into the COCC 8-bit format and writes it, plus an optional second byte, sequentially into program memory.
- Sits between the host/loader and the program RAM, so test programs can be built in hardware.

Parameters:
- ADDR_W, 8, program-memory address width; memory depth DEPTH = 2**ADDR_W bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous restart of the write pointer; lower priority than rst
- in_valid  in  1  instruction available
- in_ready  out  1  encoder can accept an instruction
- in_op  in  4  opcode enum: 0 NOP, 1 HLT, 2 CALL, 3 RET, 4 CMP, 5 ALU, 6 LDI, 7 LDX, 8 STX, 9 PUSH, 10 POP, 11 JMP, 12 MOV; 13-15 illegal
- in_a  in  3  operand1 field, bits [5:3]; MOV destination
- in_b  in  3  operand2 field, bits [2:0]; register, ALU mode or jump condition
- in_imm  in  8  immediate for LDI, target address for JMP
- mem_we  out  1  program-memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  encoded byte
- full  out  1  all DEPTH bytes written
- error  out  1  one-cycle pulse on a rejected instruction
- count  out  ADDR_W+1  bytes written since reset/clear

Behaviour:
- Encoding of byte0 (b = in_b, a = in_a):
  - NOP 0x00, HLT 0x01, CALL 0x02, RET 0x03
  - CMP 00_001_bbb, ALU 00_010_bbb, LDI 00_011_bbb, LDX 00_100_bbb
  - STX 00_101_bbb, PUSH 00_110_bbb, POP 00_111_bbb
  - JMP 10_000_bbb, MOV 01_aaa_bbb
  - in_a is ignored for every opcode except MOV.
- Byte1: LDI and JMP emit in_imm as a second byte; all other opcodes are one byte.
- FSM states:
  - IDLE: in_ready = !full. On in_valid & in_ready, latch the inputs and go to EMIT0.
  - EMIT0: mem_we = 1, mem_wdata = byte0, mem_addr = ptr; ptr++, count++. Go to EMIT1 if the instruction is two-byte, else IDLE.
  - EMIT1: mem_we = 1, mem_wdata = latched imm; ptr++, count++; go to IDLE.
- Latency: byte0 is written the cycle after acceptance; byte1 the cycle after byte0. in_ready is low in EMIT0/EMIT1.
  - Throughput: one 1-byte instruction per 2 cycles; one 2-byte instruction per 3 cycles.
- Rejection happens at acceptance, in IDLE:
  - Illegal opcode (13-15), or a two-byte opcode with only one free byte (count == DEPTH-1): the handshake completes (in_ready was 1), nothing is written, error pulses the next cycle, FSM stays in IDLE.
- full = (count == DEPTH). When full, in_ready = 0 and no writes occur. ptr is ADDR_W bits and would wrap to 0 exactly when full asserts; it is never used while full.
- clear: in any state, the next cycle gives ptr = 0, count = 0, state IDLE, and any in-flight byte1 is dropped. Writes in the clear cycle itself are suppressed (mem_we = 0).
- Reset values: state IDLE, ptr 0, count 0, mem_we 0, mem_addr 0, mem_wdata 0x00, full 0, error 0, in_ready 1 in the cycle after rst deasserts. rst mid-EMIT1 aborts with no further writes.
- mem_addr and mem_wdata are 0 whenever mem_we = 0.

Optional Feature:
- Macro: COCC_ENC_CHECKSUM_EN.
- Defined:
  - Extra output csum [7:0], the running XOR of every byte written.
  - Resets to 0x00 on rst/clear and updates in the same cycle as each mem_we.
  - Suppressed writes (error, clear) do not update it.
- Undefined: port and logic are absent; behaviour otherwise identical.

Test Plan:
- Reset, then MOV a=3 b=5 -> next cycle mem_we=1, addr 0, data 0x5D; count=1, in_ready back high the following cycle.
- LDI b=2 imm=0xA5 at addr 1 -> addr 1 data 0x1A, then addr 2 data 0xA5 on consecutive cycles; count=3.
- ALU b=4, then JMP b=1 imm=0x40 -> bytes 0x14, 0x81, 0x40 at sequential addresses.
- ADDR_W=2: write NOP, HLT, RET, then LDI -> LDI rejected with error pulse and no write. Then CALL -> 0x02 at addr 3; full=1, in_ready=0, count=4.
- in_op=14 -> error pulses 1 cycle, mem_we stays 0, count unchanged.
- Assert clear (or rst) during EMIT1 of an LDI -> immediate byte not written; next accepted NOP lands at addr 0; csum (if enabled) = 0x00 after clear.
